// File: rtl/seg7_pwm_blink_driver.sv
// ---------------------------------------------------------------------------
// seg7_pwm_blink_driver
//
// Pixel stage for one seven-segment digit. Takes the segment pattern from the
// PIO segment register and produces the active-low HEX pin drive. Brightness
// comes from PWM dimming. Blinking is optional.
//
// Build option: define SEG7_BLINK_EN to build the blink logic. Without it,
// blink_en is ignored and the digit shows whenever the PWM says "lit".
//
// Parameters:
//   PRESCALE      clk cycles per PWM step (>=1)
//   PWM_W         PWM counter / brightness width, period = 2^PWM_W steps
//   BLINK_PERIODS PWM periods per blink half-phase (>=1)
//
// Ports:
//   clk        system clock (PIO clock domain)
//   reset_n    asynchronous active-low reset
//   seg_in     segment pattern, 1 = lit (bit0 = a ... bit6 = g)
//   brightness duty level, 0 = dark, all-ones = always on
//   blink_en   enables blinking
//   seg_n      registered active-low segment drive
//   frame_tick registered one-cycle pulse at each PWM period start
// ---------------------------------------------------------------------------
module seg7_pwm_blink_driver #(
    parameter int PRESCALE      = 50,
    parameter int PWM_W         = 4,
    parameter int BLINK_PERIODS = 31250
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       seg_in,
    input  logic [PWM_W-1:0] brightness,
    input  logic             blink_en,
    output logic [6:0]       seg_n,
    output logic             frame_tick
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};

    logic [6:0]       seg_q;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0] bright_q, bright_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             frame_tick_q, frame_tick_d;
    logic             step_s, wrap_s, lit_s, show_s;

`ifdef SEG7_BLINK_EN
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_PERIODS - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    // Blink half-phase counter; a low blink_en overrides a coincident boundary
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blink_en) begin
            blink_cnt_d   = {BLK_W{1'b0}};
            blink_phase_d = 1'b1;
        end else if (wrap_s) begin
            if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_d   = {BLK_W{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLK_W'(1);
            end
        end else begin
            blink_cnt_d   = blink_cnt_q;
        end
    end

    // Blink registers; phase 1 means the digit is allowed to show
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= {BLK_W{1'b0}};
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign show_s = lit_s & (blink_phase_q | ~blink_en);
`else
    logic blink_en_unused_s;
    assign blink_en_unused_s = blink_en;
    assign show_s            = lit_s;
`endif

    // Prescaler, PWM counter, period-boundary brightness load and lit decision
    always_comb begin
        step_s = (pre_cnt_q == PRE_MAX);
        wrap_s = step_s && (pwm_cnt_q == PWM_MAX);

        if (step_s) begin
            pre_cnt_d = {PRE_W{1'b0}};
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);   // wraps all-ones -> 0
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
            pwm_cnt_d = pwm_cnt_q;
        end

        // Brightness only changes at a period boundary, so a period never
        // mixes two duty levels.
        if (wrap_s) begin
            bright_d = brightness;
        end else begin
            bright_d = bright_q;
        end

        // All-ones must be fully on; the plain compare would leave one step dark.
        if (bright_q == PWM_MAX) begin
            lit_s = 1'b1;
        end else begin
            lit_s = (pwm_cnt_q < bright_q);
        end

        seg_n_d      = ~(seg_q & {7{show_s}});
        frame_tick_d = wrap_s;
    end

    // Pattern capture, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q        <= 7'h00;
            pre_cnt_q    <= {PRE_W{1'b0}};
            pwm_cnt_q    <= {PWM_W{1'b0}};
            bright_q     <= {PWM_W{1'b0}};
            seg_n_q      <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_in;
            pre_cnt_q    <= pre_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            bright_q     <= bright_d;
            seg_n_q      <= seg_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_pwm_blink_driver.sv
// ---------------------------------------------------------------------------
// Testbench for seg7_pwm_blink_driver (PRESCALE=2, PWM_W=2, BLINK_PERIODS=2).
// The reference model works from the elapsed cycle count since reset: the
// PWM position is a division of that count, and the blink phase comes from
// the number of period boundaries seen since blink_en was last low. It
// follows whether SEG7_BLINK_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_seg7_pwm_blink_driver;

    localparam int PRESCALE      = 2;
    localparam int PWM_W         = 2;
    localparam int BLINK_PERIODS = 2;
    localparam int STEPS         = 1 << PWM_W;
    localparam int PERIOD        = PRESCALE * STEPS;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [6:0]       seg_in     = 7'h00;
    logic [PWM_W-1:0] brightness = '0;
    logic             blink_en   = 1'b0;
    logic [6:0]       seg_n;
    logic             frame_tick;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         cyc;       // clock edges since reset release
    int         bright_m;  // brightness latched at last boundary
    int         nb;        // boundaries since blink_en was last low
    logic [6:0] seg_m;     // pattern captured at last edge
    logic [6:0] exp_seg;
    logic       exp_ft;

    seg7_pwm_blink_driver #(
        .PRESCALE      (PRESCALE),
        .PWM_W         (PWM_W),
        .BLINK_PERIODS (BLINK_PERIODS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .brightness (brightness),
        .blink_en   (blink_en),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic bit phase_on(input int n);
        return ((n / BLINK_PERIODS) % 2) == 0;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        bright_m = 0;
        nb       = 0;
        seg_m    = 7'h00;
        exp_seg  = 7'h7F;
        exp_ft   = 1'b0;
    endtask

    // One clock: advance the model at the rising edge, return at the falling edge
    task automatic tick();
        bit lit;
        bit show;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (bright_m == STEPS - 1) lit = 1'b1;
            else                       lit = ((cyc / PRESCALE) % STEPS) < bright_m;
            show    = lit && (!BLINK_BUILT || !blink_en || phase_on(nb));
            exp_seg = show ? ~seg_m : 7'h7F;
            cyc++;
            exp_ft = (cyc % PERIOD) == 0;
            if (cyc % PERIOD == 0) bright_m = int'(brightness);
            if (!blink_en)              nb = 0;
            else if (cyc % PERIOD == 0) nb++;
            seg_m = seg_in;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] want_seg;
        logic       want_ft;
        reset_n    = 1'b0;
        seg_in     = 7'h3F;
        brightness = 2'd3;
        blink_en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (seg_n !== 7'h7F || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold seg_n=%h ft=%b want 7f/0", seg_n, frame_tick);
            end
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            want_seg = (i <= 8) ? 7'h7F : 7'h40;
            want_ft  = (i % 8) == 0;
            checks++;
            if (seg_n !== want_seg) begin
                errors++;
                $display("FAIL reset_release_seg cycle=%0d got %h want %h", i, seg_n, want_seg);
            end
            checks++;
            if (frame_tick !== want_ft) begin
                errors++;
                $display("FAIL reset_release_ft cycle=%0d got %b want %b", i, frame_tick, want_ft);
            end
        end
    endtask

    task automatic test_pwm_duty();
        int lit_cnt = 0;
        int ft_cnt  = 0;
        brightness = 2'd1;
        seg_in     = 7'h7F;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 16) begin
                if (seg_n === 7'h00) lit_cnt++;
                if (frame_tick === 1'b1) ft_cnt++;
                checks++;
                if (seg_n !== 7'h00 && seg_n !== 7'h7F) begin
                    errors++;
                    $display("FAIL duty_level got %h want 00 or 7f", seg_n);
                end
            end
            checks++;
            if (seg_n !== exp_seg || frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL duty_model cyc=%0d got %h/%b want %h/%b", cyc, seg_n, frame_tick, exp_seg, exp_ft);
            end
        end
        checks++;
        if (lit_cnt != 6) begin
            errors++;
            $display("FAIL duty_on_count got %0d want 6", lit_cnt);
        end
        checks++;
        if (ft_cnt != 3) begin
            errors++;
            $display("FAIL frame_tick_count got %0d want 3", ft_cnt);
        end
    endtask

    task automatic test_brightness_change();
        int  old_lit = 0;
        int  new_lit = 0;
        bit  seen    = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            tick();
            seen = frame_tick;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bright_align no frame_tick within 16 cycles");
        end
        tick();
        tick();
        brightness = 2'd2;
        for (int k = 3; k <= 16; k++) begin
            tick();
            if (k <= 8 && seg_n === 7'h00) old_lit++;
            if (k >= 9 && seg_n === 7'h00) new_lit++;
            checks++;
            if (seg_n !== exp_seg || frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL bright_model cyc=%0d got %h/%b want %h/%b", cyc, seg_n, frame_tick, exp_seg, exp_ft);
            end
        end
        checks++;
        if (old_lit != 0) begin
            errors++;
            $display("FAIL bright_old_tail on-cycles got %0d want 0", old_lit);
        end
        checks++;
        if (new_lit != 4) begin
            errors++;
            $display("FAIL bright_new_period on-cycles got %0d want 4", new_lit);
        end
        brightness = 2'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i >= 16) begin
                checks++;
                if (seg_n !== 7'h7F) begin
                    errors++;
                    $display("FAIL bright_zero got %h want 7f", seg_n);
                end
            end
        end
    endtask

    task automatic test_blink();
        bit off = 1'b0;
        brightness = 2'd3;
        seg_in     = 7'h06;
        blink_en   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (seg_n !== exp_seg || frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL blink_model cyc=%0d got %h/%b want %h/%b", cyc, seg_n, frame_tick, exp_seg, exp_ft);
            end
        end
        for (int i = 0; i < 64 && !off; i++) begin
            tick();
            off = !phase_on(nb) && (bright_m == 3);
        end
        checks++;
        if (!off) begin
            errors++;
            $display("FAIL blink_align off-phase not reached");
        end
        tick();
        blink_en = 1'b0;
        tick();
        tick();
        checks++;
        if (seg_n !== 7'h79) begin
            errors++;
            $display("FAIL blink_drop got %h want 79", seg_n);
        end
    endtask

    task automatic test_async_reset();
        bit ready = 1'b0;
        brightness = 2'd2;
        seg_in     = 7'h06;
        blink_en   = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        for (int i = 0; i < 40 && !ready; i++) begin
            tick();
            ready = (exp_seg != 7'h7F) && (cyc % PERIOD != 0);
        end
        checks++;
        if (seg_n !== 7'h79) begin
            errors++;
            $display("FAIL areset_pre got %h want 79", seg_n);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (seg_n !== 7'h7F || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate seg_n=%h ft=%b want 7f/0", seg_n, frame_tick);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            checks++;
            if (frame_tick !== ((i % 8) == 0)) begin
                errors++;
                $display("FAIL areset_restart_ft cycle=%0d got %b", i, frame_tick);
            end
            checks++;
            if (seg_n !== exp_seg) begin
                errors++;
                $display("FAIL areset_restart_seg cycle=%0d got %h want %h", i, seg_n, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            seg_in = 7'($urandom_range(127, 0));
            if ($urandom_range(7, 0) == 0) brightness = PWM_W'($urandom_range(STEPS - 1, 0));
            if ($urandom_range(39, 0) == 0) blink_en = ~blink_en;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(149, 0) == 0) reset_n = 1'b0;
            tick();
            checks++;
            if (seg_n !== exp_seg) begin
                errors++;
                $display("FAIL random_seg cyc=%0d got %h want %h", cyc, seg_n, exp_seg);
            end
            checks++;
            if (frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL random_ft cyc=%0d got %b want %b", cyc, frame_tick, exp_ft);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pwm_duty();
        test_brightness_change();
        test_blink();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
